serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
// - Bit-serial add/subtract sequencer around one fulladder cell; reuses the existing 1-bit adder.
// - Latches two WIDTH-bit operands and feeds one bit pair per clock, LSB first, into the cell.
// - Recirculates the cell carry-out as the next carry-in and shifts sums into a result register.
// - Serves the CPU datapath as an area-minimal ALU adder path; start/busy/done handshake to the issuer.
// PARAMETERS
// - WIDTH  8  operand/result width in bits (>=2)
// PORTS
// - clk       in   1      system clock, rising edge
// - rst       in   1      synchronous reset, active-high
// - start     in   1      request; sampled only in IDLE
// - sub       in   1      0: a+b, 1: a-b (two's complement); sampled with start
// - a         in   WIDTH  operand A; sampled with start
// - b         in   WIDTH  operand B; sampled with start
// - busy      out  1      high while bits are being processed (RUN)
// - done      out  1      one-cycle pulse: result/cout/ovf valid
// - result    out  WIDTH  sum/difference; held until next accepted start
// - cout      out  1      final carry-out (for sub: 1 = no borrow)
// - ovf       out  1      signed overflow = carry into MSB ^ carry out of MSB
// BEHAVIOUR
// - Clock/reset: single clk; rst synchronous active-high; all state updates on rising clk.
// - Reset: state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; bit counter=0, carry reg=0.
// - rst has priority over everything, including mid-RUN: operation aborted, no done pulse.
// - FSM states: IDLE, RUN, DONE.
// - IDLE: start=1 -> latch a, b^{WIDTH{sub}}, carry=sub, cnt=0, clear result; -> RUN.
//   start=0 -> stay.
// - RUN, per cycle: cell x=a_sh[0], y=b_sh[0], cin=carry.
//   - result <= {sum, result[WIDTH-1:1]}; a_sh/b_sh shift right one bit.
//   - carry <= cell cout; cnt++.
// - RUN, when cnt==WIDTH-2: also capture carry_msb_in <= cell cout (carry into MSB).
// - RUN, when cnt==WIDTH-1 (last bit):
//   - cout <= cell cout; ovf <= cell cout ^ carry_msb_in; -> DONE.
// - DONE: done=1 for exactly this cycle; busy=0; -> IDLE unconditionally.
// - Start handling: start ignored in RUN and DONE (not queued); issuer re-asserts after done.
// - Latency: start sampled on edge E0; done visible after edge E0+WIDTH; next start accepted
//   at edge E0+WIDTH+2; throughput one op per WIDTH+2 cycles.
// - busy=1 exactly WIDTH cycles per op; busy and done never high together.
// - result/cout/ovf stable from DONE until the next accepted start (cleared at that edge).
// - Width rules: result wraps mod 2^WIDTH; cnt width $clog2(WIDTH).
// - Inputs a/b/sub may change freely after the start edge without effect.
// STRUCTURE
// - Package serial_add_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t.
// - Sub-module: one fulladder instance (x, y, cin -> sum, cout); all else inline in this module.
// - Registers: state, cnt, a_sh, b_sh, carry, carry_msb_in, result, cout, ovf.
// TESTING
// - Reset: rst high 2 cycles mid-RUN -> busy=0, done=0, result=0; no done pulse follows.
// - Add, WIDTH=8: a=8'h3C, b=8'h05, sub=0 -> done after 8 edges.
//   result=8'h41, cout=0, ovf=0; busy high 8 cycles.
// - Carry/overflow: a=8'hFF, b=8'h01 -> result=8'h00, cout=1, ovf=0.
//   a=8'h7F, b=8'h01 -> result=8'h80, cout=0, ovf=1.
// - Subtract: a=8'h05, b=8'h07, sub=1 -> result=8'hFE, cout=0, ovf=0.
//   a=8'h80, b=8'h01, sub=1 -> result=8'h7F, ovf=1.
// - Start in RUN ignored: pulse start with a=8'h11 at cycle 3 of an op.
//   Current result unaffected; no second done.
// - Back-to-back: start held high continuously.
//   Ops accepted every WIDTH+2 cycles; each result matches a reference model.
// - Exhaustive: WIDTH=4, all a, b, sub -> result/cout/ovf match a+b / a-b model.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types for the bit-serial add/subtract sequencer
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain combinational sum and majority carry
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract sequencer around one full adder cell
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  import serial_add_pkg::*;

  localparam int CW = $clog2(WIDTH);
  // Counter value of the bit feeding the MSB, and of the MSB itself
  localparam logic [CW-1:0] CNT_PRE_MSB = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST    = CW'(WIDTH - 1);

  sa_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             carry_msb_in;

  logic             fa_sum;
  logic             fa_cout;

  fulladder u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sequencer: latch operands, walk bits LSB first, then pulse done for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      a_sh         <= '0;
      b_sh         <= '0;
      carry        <= 1'b0;
      carry_msb_in <= 1'b0;
      result       <= '0;
      cout         <= 1'b0;
      ovf          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with sub
            a_sh   <= a;
            b_sh   <= b ^ {WIDTH{sub}};
            carry  <= sub;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          result <= {fa_sum, result[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_PRE_MSB) begin
            carry_msb_in <= fa_cout;
          end
          if (cnt == CNT_LAST) begin
            cout  <= fa_cout;
            ovf   <= fa_cout ^ carry_msb_in;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl at WIDTH 8 and 4
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] result8;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
  );

  // WIDTH=4 instance
  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, ovf4;
  logic [3:0] result4;

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: {result[7:0], cout, ovf} from integer arithmetic and sign rules
  function automatic logic [9:0] model(input int w, input int a, input int b, input bit s);
    int m;
    int r;
    bit c, o, am, bm, rm;
    m = 1 << w;
    a = a % m;
    b = b % m;
    if (!s) begin
      r = a + b;
      c = (r >= m);
    end else begin
      r = a - b + m;
      c = (a >= b);
    end
    r  = r % m;
    am = ((a >> (w - 1)) & 1) != 0;
    bm = ((b >> (w - 1)) & 1) != 0;
    rm = ((r >> (w - 1)) & 1) != 0;
    o  = s ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
    return {r[7:0], c, o};
  endfunction

  logic [9:0] exp8_q[$];
  logic [9:0] exp4_q[$];
  int done8_cnt = 0;
  int done4_cnt = 0;
  int last_done8_cyc = 0;

  // Scoreboard pop for the 8-bit instance
  always @(negedge clk) begin
    if (!rst && done8) begin
      logic [9:0] e;
      done8_cnt++;
      last_done8_cyc = cyc;
      check("busy_done_excl8", {31'd0, busy8}, 32'd0);
      if (exp8_q.size() == 0) begin
        check("spurious_done8", 32'd1, 32'd0);
      end else begin
        e = exp8_q.pop_front();
        check("result8", {24'd0, result8}, {24'd0, e[9:2]});
        check("cout8", {31'd0, cout8}, {31'd0, e[1]});
        check("ovf8", {31'd0, ovf8}, {31'd0, e[0]});
      end
    end
  end

  // Scoreboard pop for the 4-bit instance
  always @(negedge clk) begin
    if (!rst && done4) begin
      logic [9:0] e;
      done4_cnt++;
      if (exp4_q.size() == 0) begin
        check("spurious_done4", 32'd1, 32'd0);
      end else begin
        e = exp4_q.pop_front();
        check("result4", {28'd0, result4}, {28'd0, e[5:2]});
        check("cout4", {31'd0, cout4}, {31'd0, e[1]});
        check("ovf4", {31'd0, ovf4}, {31'd0, e[0]});
      end
    end
  end

  // One 8-bit op; optionally pulses start with a=8'h11 while RUN is at pulse_at
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [9:0] e, input int pulse_at);
    int edges;
    int busyc;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    exp8_q.push_back(e);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    a8 = $urandom; b8 = $urandom; sub8 = $urandom_range(0, 1);
    edges = 0;
    busyc = 0;
    forever begin
      @(negedge clk);
      if (done8 || edges >= 40) break;
      if (busy8) busyc++;
      if (edges == pulse_at) begin
        start8 = 1'b1;
        a8 = 8'h11;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk);
      edges++;
    end
    start8 = 1'b0;
    if (edges >= 40) check("timeout8", 32'd0, 32'd1);
    check("latency8", edges, 32'd8);
    check("busy_cycles8", busyc, 32'd8);
    @(negedge clk);
    check("done_pulse8", {31'd0, done8}, 32'd0);
    check("hold_result8", {24'd0, result8}, {24'd0, e[9:2]});
  endtask

  initial begin
    int snap;
    int prev;
    int waited;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_result8", {24'd0, result8}, 32'd0);
    check("rst_cout8", {31'd0, cout8}, 32'd0);
    check("rst_ovf8", {31'd0, ovf8}, 32'd0);
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    rst = 1'b0;

    // Directed cases
    run8(8'h3C, 8'h05, 1'b0, {8'h41, 1'b0, 1'b0}, -1);
    run8(8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b0}, -1);
    run8(8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1}, -1);
    run8(8'h05, 8'h07, 1'b1, {8'hFE, 1'b0, 1'b0}, -1);
    run8(8'h80, 8'h01, 1'b1, {8'h7F, 1'b1, 1'b1}, -1);

    // Start pulse during RUN must be ignored
    snap = done8_cnt;
    run8(8'h22, 8'h33, 1'b0, {8'h55, 1'b0, 1'b0}, 3);
    repeat (14) @(negedge clk);
    check("ignored_start_no_done", done8_cnt - snap, 32'd1);

    // Reset mid-RUN aborts without a done pulse
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy8", {31'd0, busy8}, 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_busy8", {31'd0, busy8}, 32'd0);
    check("abort_done8", {31'd0, done8}, 32'd0);
    check("abort_result8", {24'd0, result8}, 32'd0);
    rst = 1'b0;
    snap = done8_cnt;
    repeat (14) @(negedge clk);
    check("abort_no_done8", done8_cnt - snap, 32'd0);

    // Back-to-back with start held high: ops every WIDTH+2 cycles
    @(negedge clk);
    start8 = 1'b1;
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] ra, rb;
      logic rs;
      ra = $urandom; rb = $urandom; rs = $urandom_range(0, 1);
      a8 = ra; b8 = rb; sub8 = rs;
      exp8_q.push_back(model(8, int'(ra), int'(rb), rs));
      snap = done8_cnt;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (done8_cnt == snap && waited < 40);
      if (waited >= 40) check("timeout_b2b", 32'd0, 32'd1);
      if (k > 0) check("b2b_period", last_done8_cyc - prev, 32'd10);
      prev = last_done8_cyc;
    end
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_queue_empty", exp8_q.size(), 32'd0);

    // Exhaustive WIDTH=4
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          @(negedge clk);
          a4 = 4'(i); b4 = 4'(j); sub4 = s[0]; start4 = 1'b1;
          exp4_q.push_back(model(4, i, j, s[0]));
          snap = done4_cnt;
          @(posedge clk);
          #1 start4 = 1'b0;
          a4 = $urandom; b4 = $urandom;
          waited = 0;
          do begin
            @(negedge clk);
            waited++;
          end while (done4_cnt == snap && waited < 20);
          if (waited >= 20) check("timeout4", 32'd0, 32'd1);
        end
      end
    end
    repeat (4) @(negedge clk);
    check("exh_queue_empty", exp4_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
